// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS control unit:
//   FSM state encoding, opcode / funct constants and ALU operation codes.
//   Imported by mips_alu_decode and mips_multicycle_control.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HLT  = 6'h3D;
  localparam logic [5:0] OP_IN   = 6'h3E;
  localparam logic [5:0] OP_OUT  = 6'h3F;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes driven on AluOP
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_SLT  = 6'd4;
  localparam logic [5:0] ALU_SLL  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_PASS = 6'd7;

  // Instructions whose second ALU operand is the sign-extended immediate
  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_LW)   || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// mips_alu_decode
//   Purely combinational (opcode, funct) -> ALU operation decoder.
//   Also flags any opcode, or R-type funct, that the core does not implement.
//   The primary opcode and R-type function field come in on op and funct;
//   alu_op carries the selected ALU operation code and illegal is raised for
//   any combination the core cannot execute.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [5:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          // JR only needs the register value routed to the PC
          FN_JR:   alu_op = ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_SLTI:               alu_op = ALU_SLT;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
      OP_J, OP_JAL, OP_OUT, OP_IN: alu_op = ALU_PASS;
      OP_HLT:                alu_op = ALU_ADD;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multi-cycle control FSM for the 32-bit MIPS process unit. Sequences each
//   instruction through FETCH, DECODE, EXEC, MEM, WB (plus WAIT_IN for the
//   switch-input instruction and HALT), and drives datapath strobes that are
//   decoded from the current state and the opcode/funct latched in DECODE.
//
//   Build option: define ILLEGAL_TRAP_EN to make an unimplemented
//   opcode/funct halt the core and raise the sticky IllegalOp output.
//   Without it, an unimplemented instruction retires as a two-cycle NOP.
//
//   Ports:
//     Clk, Rst_n         clock (rising edge), asynchronous active-low reset
//     OpCode, Funct      instruction fields, sampled in DECODE
//     InputValid         synchronised switch-entry button
//     PcWrite, IrWrite   PC update / instruction register load
//     AluOP              ALU operation code
//     RegDst..Print      datapath control strobes
//     InputAck           one-cycle pulse when an IN instruction takes the input
//     Halted             core stopped (only reset leaves)
//     State              current FSM state (debug)
//     RetireCount        instructions completed, wraps
//     IllegalOp          sticky illegal-instruction flag (ILLEGAL_TRAP_EN only)
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int RETIRE_W = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [OP_W-1:0]     OpCode,
  input  logic [OP_W-1:0]     Funct,
  input  logic                InputValid,
  output logic                PcWrite,
  output logic                IrWrite,
  output logic [5:0]          AluOP,
  output logic                RegDst,
  output logic                Branch,
  output logic                JumpReg,
  output logic                Jump,
  output logic                Jal,
  output logic                And,
  output logic                MemRead,
  output logic                MemToReg,
  output logic                MemWrite,
  output logic                Immediate,
  output logic                RegWrite,
  output logic                Print,
  output logic                InputAck,
  output logic                Halted,
  output logic [2:0]          State,
`ifdef ILLEGAL_TRAP_EN
  output logic                IllegalOp,
`endif
  output logic [RETIRE_W-1:0] RetireCount
);

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q, op_d;
  logic [OP_W-1:0]       funct_q, funct_d;
  logic                  armed_q, armed_d;
  logic [RETIRE_W-1:0]   retire_q, retire_d;
  logic                  retire_inc;
`ifdef ILLEGAL_TRAP_EN
  logic                  illegal_q, illegal_d;
`endif

  logic [5:0]            dec_op, dec_funct, dec_alu;
  logic                  dec_illegal;

  // In DECODE the fields are still on the parser outputs; afterwards only
  // the latched copy is valid.
  assign dec_op    = 6'((state_q == ST_DECODE) ? OpCode : op_q);
  assign dec_funct = 6'((state_q == ST_DECODE) ? Funct  : funct_q);

  mips_alu_decode u_alu_decode (
    .op      (dec_op),
    .funct   (dec_funct),
    .alu_op  (dec_alu),
    .illegal (dec_illegal)
  );

  // Output decode: depends only on registered state and latched fields
  // (plus the live fields in DECODE), so reset clears every strobe at once.
  always_comb begin
    PcWrite   = 1'b0;
    IrWrite   = 1'b0;
    AluOP     = ALU_ADD;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    JumpReg   = 1'b0;
    Jump      = 1'b0;
    Jal       = 1'b0;
    And       = 1'b0;
    MemRead   = 1'b0;
    MemToReg  = 1'b0;
    MemWrite  = 1'b0;
    Immediate = 1'b0;
    RegWrite  = 1'b0;
    Print     = 1'b0;
    InputAck  = 1'b0;
    Halted    = 1'b0;
    case (state_q)
      ST_FETCH: IrWrite = 1'b1;
      ST_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        // Unimplemented instruction retires here as a NOP
        if (dec_illegal) PcWrite = 1'b1;
`endif
      end
      ST_EXEC: begin
        AluOP     = dec_alu;
        Immediate = is_imm_op(6'(op_q));
        case (6'(op_q))
          OP_BEQ, OP_BNE: begin
            Branch  = 1'b1;
            And     = 1'b1;
            PcWrite = 1'b1;
          end
          OP_J: begin
            Jump    = 1'b1;
            PcWrite = 1'b1;
          end
          OP_JAL: begin
            Jump     = 1'b1;
            Jal      = 1'b1;
            RegWrite = 1'b1;
            PcWrite  = 1'b1;
          end
          OP_OUT: begin
            Print   = 1'b1;
            PcWrite = 1'b1;
          end
          OP_R: begin
            if (6'(funct_q) == FN_JR) begin
              JumpReg = 1'b1;
              PcWrite = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        AluOP     = ALU_ADD;
        Immediate = 1'b1;
        if (6'(op_q) == OP_LW) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          PcWrite  = 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PcWrite  = 1'b1;
        RegDst   = (6'(op_q) == OP_R);
        MemToReg = (6'(op_q) == OP_LW);
        if (6'(op_q) == OP_IN) begin
          AluOP    = ALU_PASS;
          InputAck = 1'b1;
        end
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  // Next-state and bookkeeping. PcWrite marks the final cycle of every
  // instruction, so it doubles as the "go back to FETCH" condition.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = OpCode;
        funct_d = Funct;
        if (6'(OpCode) == OP_HLT) begin
          state_d = ST_HALT;
        end else if (6'(OpCode) == OP_IN) begin
          state_d = ST_WAIT_IN;
        end else if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = ST_HALT;
          illegal_d = 1'b1;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (PcWrite)
          state_d = ST_FETCH;
        else if (6'(op_q) == OP_LW || 6'(op_q) == OP_SW)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_MEM:     state_d = PcWrite ? ST_FETCH : ST_WB;
      ST_WB:      state_d = ST_FETCH;
      ST_WAIT_IN: if (InputValid && armed_q) state_d = ST_WB;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase

    // A released button re-arms; taking the input disarms until release.
    if (!InputValid)
      armed_d = 1'b1;
    else if (InputAck)
      armed_d = 1'b0;
    else
      armed_d = armed_q;

    // HLT counts as retired on its way into HALT
    retire_inc = PcWrite || (state_q == ST_DECODE && 6'(OpCode) == OP_HLT);
    retire_d   = retire_q + {{(RETIRE_W-1){1'b0}}, retire_inc};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_FETCH;
      op_q     <= '0;
      funct_q  <= '0;
      armed_q  <= 1'b1;
      retire_q <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      funct_q  <= funct_d;
      armed_q  <= armed_d;
      retire_q <= retire_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign State       = state_q;
  assign RetireCount = retire_q;
`ifdef ILLEGAL_TRAP_EN
  assign IllegalOp   = illegal_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [5:0]  OpCode = '0;
  logic [5:0]  Funct = '0;
  logic        InputValid = 1'b0;
  logic        PcWrite, IrWrite, RegDst, Branch, JumpReg, Jump, Jal, And;
  logic        MemRead, MemToReg, MemWrite, Immediate, RegWrite, Print;
  logic        InputAck, Halted;
  logic [5:0]  AluOP;
  logic [2:0]  State;
  logic [15:0] RetireCount;
`ifdef ILLEGAL_TRAP_EN
  logic        IllegalOp;
`endif

  mips_multicycle_control #(.OP_W(6), .RETIRE_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .OpCode(OpCode), .Funct(Funct),
    .InputValid(InputValid), .PcWrite(PcWrite), .IrWrite(IrWrite),
    .AluOP(AluOP), .RegDst(RegDst), .Branch(Branch), .JumpReg(JumpReg),
    .Jump(Jump), .Jal(Jal), .And(And), .MemRead(MemRead),
    .MemToReg(MemToReg), .MemWrite(MemWrite), .Immediate(Immediate),
    .RegWrite(RegWrite), .Print(Print), .InputAck(InputAck),
    .Halted(Halted), .State(State),
`ifdef ILLEGAL_TRAP_EN
    .IllegalOp(IllegalOp),
`endif
    .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  // Control strobe bit positions within ctrl_vec
  localparam logic [15:0] PC  = 16'h8000, IR  = 16'h4000, RD  = 16'h2000;
  localparam logic [15:0] BR  = 16'h1000, JRB = 16'h0800, JB  = 16'h0400;
  localparam logic [15:0] JLB = 16'h0200, ANB = 16'h0100, MR  = 16'h0080;
  localparam logic [15:0] M2R = 16'h0040, MW  = 16'h0020, IMM = 16'h0010;
  localparam logic [15:0] RW  = 16'h0008, PR  = 16'h0004, ACK = 16'h0002;
  localparam logic [15:0] HL  = 16'h0001;

  logic [15:0] ctrl_vec;
  assign ctrl_vec = {PcWrite, IrWrite, RegDst, Branch, JumpReg, Jump, Jal, And,
                     MemRead, MemToReg, MemWrite, Immediate, RegWrite, Print,
                     InputAck, Halted};

  // Instruction classes of the reference model
  localparam int C_R = 0, C_JR = 1, C_IMM = 2, C_LW = 3, C_SW = 4, C_BR = 5;
  localparam int C_J = 6, C_JAL = 7, C_OUT = 8, C_IN = 9, C_HLT = 10, C_ILL = 11;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic armed_m = 1'b1;
  int   retire_m = 0;
  logic ill_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        if (fn == 6'h08) return C_JR;
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02}) return C_R;
        return C_ILL;
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: return C_IMM;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      6'h3F: return C_OUT;
      6'h3E: return C_IN;
      6'h3D: return C_HLT;
      default: return C_ILL;
    endcase
  endfunction

  // ALU code the instruction computes with in EXEC
  function automatic logic [5:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
        6'h20: return 6'd0;  6'h22: return 6'd1;  6'h24: return 6'd2;
        6'h25: return 6'd3;  6'h2A: return 6'd4;  6'h00: return 6'd5;
        6'h02: return 6'd6;  default: return 6'd0;
      endcase
      6'h0A: return 6'd4;
      6'h0C: return 6'd2;
      6'h0D: return 6'd3;
      6'h04, 6'h05: return 6'd1;
      default: return 6'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the armed-flag model, then step past the rising edge.
  task automatic cyc(input logic [2:0] est, input logic [15:0] ectrl,
                     input bit chk_alu, input logic [5:0] ealu,
                     input logic [5:0] op_in, input logic [5:0] fn_in,
                     input logic iv);
    OpCode = op_in;
    Funct = fn_in;
    InputValid = iv;
    @(negedge Clk);
    chk($sformatf("state(exp st %0d)", est), 32'(State), 32'(est));
    chk($sformatf("ctrl(st %0d)", est), 32'(ctrl_vec), 32'(ectrl));
    if (chk_alu) chk($sformatf("aluop(st %0d)", est), 32'(AluOP), 32'(ealu));
    if (!iv) armed_m = 1'b1;
    else if ((ectrl & ACK) != 0) armed_m = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #2;
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_ctrl", 32'(ctrl_vec), 32'(IR));
    chk("reset_alu", 32'(AluOP), 32'd0);
    chk("reset_retire", 32'(RetireCount), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    chk("reset_illegal", 32'(IllegalOp), 32'd0);
`endif
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    armed_m = 1'b1;
    retire_m = 0;
    ill_m = 1'b0;
  endtask

  // mode: 0 random InputValid, 1 held high, 2 high / one low cycle / high
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mode);
    int   c;
    int   k;
    logic iv;
    logic go;
    logic [15:0] dec_ctrl;
    c = classify(op, fn);
    dec_ctrl = '0;
`ifndef ILLEGAL_TRAP_EN
    if (c == C_ILL) dec_ctrl = PC;
`endif
    cyc(3'd0, IR, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
    cyc(3'd1, dec_ctrl, 1, 6'd0, op, fn, (mode == 0) ? rbit() : 1'b1);
    case (c)
      C_R: begin
        cyc(3'd2, 16'h0, 1, alu_of(op, fn), rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        cyc(3'd4, RW | PC | RD, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_IMM: begin
        cyc(3'd2, IMM, 1, alu_of(op, fn), rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        cyc(3'd4, RW | PC, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_LW: begin
        cyc(3'd2, IMM, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        cyc(3'd3, IMM | MR, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        cyc(3'd4, RW | PC | M2R, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_SW: begin
        cyc(3'd2, IMM, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        cyc(3'd3, IMM | MW | PC, 1, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_BR: begin
        cyc(3'd2, BR | ANB | PC, 1, 6'd1, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_J: begin
        cyc(3'd2, JB | PC, 0, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_JAL: begin
        cyc(3'd2, JB | JLB | RW | PC, 0, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_JR: begin
        cyc(3'd2, JRB | PC, 0, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_OUT: begin
        cyc(3'd2, PR | PC, 0, 6'd0, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
        retire_m++;
      end
      C_IN: begin
        k = 0;
        go = 1'b0;
        while (!go && k < 200) begin
          if (mode == 0) iv = rbit();
          else if (mode == 2) iv = (k != 3);
          else iv = 1'b1;
          go = iv && armed_m;
          cyc(3'd5, 16'h0, 1, 6'd0, rop(), rop(), iv);
          k++;
        end
        chk("in_wait_bounded", 32'(go), 32'd1);
        if (mode == 2) chk("in_wait_cycles", 32'(k), 32'd5);
        if (go) begin
          cyc(3'd4, RW | PC | ACK, 1, 6'd7, rop(), rop(), (mode == 0) ? rbit() : 1'b1);
          retire_m++;
        end
      end
      C_HLT: begin
        retire_m++;
        for (int i = 0; i < 100; i++)
          cyc(3'd6, HL, 1, 6'd0, rop(), rop(), rbit());
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        ill_m = 1'b1;
        for (int i = 0; i < 5; i++)
          cyc(3'd6, HL, 1, 6'd0, rop(), rop(), rbit());
`else
        retire_m++;
`endif
      end
    endcase
    chk($sformatf("retire(op %0h)", op), 32'(RetireCount), 32'(retire_m[15:0]));
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_flag", 32'(IllegalOp), 32'(ill_m));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [13];
    logic [5:0] bad [8];
    logic [5:0] fns [8];
    logic [5:0] op;
    logic [5:0] fn;
    int r;
    ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05,
            6'h02, 6'h03, 6'h3F, 6'h3E};
    bad = '{6'h01, 6'h06, 6'h07, 6'h09, 6'h10, 6'h1F, 6'h20, 6'h3C};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};

    do_reset();

    // Directed instructions
    run_instr(6'h00, 6'h20, 1);  // ADD
    run_instr(6'h23, rop(), 1);  // LW
    run_instr(6'h2B, rop(), 1);  // SW
    run_instr(6'h04, rop(), 1);  // BEQ
    run_instr(6'h03, rop(), 1);  // JAL
    run_instr(6'h00, 6'h08, 1);  // JR
    run_instr(6'h3E, rop(), 1);  // IN, button held
    run_instr(6'h3E, rop(), 2);  // IN, same press must not count twice
    run_instr(6'h1F, rop(), 1);  // illegal opcode
`ifdef ILLEGAL_TRAP_EN
    do_reset();
`endif

    // Reset asserted while ADDI is in EXEC
    cyc(3'd0, IR, 1, 6'd0, rop(), rop(), 1'b1);
    cyc(3'd1, 16'h0, 1, 6'd0, 6'h08, rop(), 1'b1);
    chk("addi_in_exec", 32'(State), 32'd2);
    chk("addi_exec_imm", 32'(Immediate), 32'd1);
    do_reset();
    chk("addi_no_regwrite", 32'(RegWrite), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
`ifdef ILLEGAL_TRAP_EN
      r = int'($urandom_range(0, 12));
`else
      r = int'($urandom_range(0, 15));
`endif
      op = (r < 13) ? ops[r] : bad[$urandom_range(0, 7)];
`ifdef ILLEGAL_TRAP_EN
      fn = (op == 6'h00) ? fns[$urandom_range(0, 7)] : rop();
`else
      fn = (op == 6'h00 && $urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 7)] : rop();
`endif
      run_instr(op, fn, 0);
    end

    // Halt for good
    run_instr(6'h3D, rop(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle control FSM that drives the control inputs of the 32-bit MIPS process unit.
- Consumes OpCode/Funct from the instruction parser and sequences each instruction through fetch, decode, execute, memory and writeback.
- Emits per-state control strobes, PC/IR write enables, the switch-input handshake and halt status.
- Sits beside the process unit at top level, on the same clock.

Parameters:
OP_W, 6, opcode and funct width
RETIRE_W, 16, width of retired-instruction counter

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
OpCode  in  OP_W  instr[31:26] from parser, valid during DECODE
Funct  in  OP_W  instr[5:0], valid during DECODE
InputValid  in  1  switch-entry button (already synchronised)
PcWrite  out  1  PC update enable
IrWrite  out  1  instruction register load
AluOP  out  6  ALU operation code
RegDst, Branch, JumpReg, Jump, Jal, And, MemRead, MemToReg, MemWrite, Immediate, RegWrite, Print  out  1 each  datapath controls
InputAck  out  1  input accepted pulse
Halted  out  1  core halted
State  out  3  current FSM state (debug)
RetireCount  out  RETIRE_W  instructions completed

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Rst_n).
- On reset: state=FETCH, latched op/funct=0, RetireCount=0, Armed=1, all outputs 0 except IrWrite=1 (FETCH decode).
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, WAIT_IN=5, HALT=6.
- Outputs are Moore-decoded from state plus op/funct latched at DECODE; unlisted outputs are 0.
- FETCH: IrWrite=1 -> DECODE.
- DECODE: latch OpCode/Funct, then:
  - HLT (0x3D) -> HALT
  - IN (0x3E) -> WAIT_IN
  - any other legal op -> EXEC
  - illegal op -> FETCH, with PcWrite=1 (NOP)
- Opcodes: R=0x00, ADDI=0x08, SLTI=0x0A, ANDI=0x0C, ORI=0x0D, LW=0x23, SW=0x2B, BEQ=0x04, BNE=0x05, J=0x02, JAL=0x03, OUT=0x3F. JR is R-type with funct 0x08.
- AluOP encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, PASS=7.
- R-type funct map: 0x20->ADD, 0x22->SUB, 0x24->AND, 0x25->OR, 0x2A->SLT, 0x00->SLL, 0x02->SRL. Any other funct except 0x08 is illegal.
- EXEC:
  - AluOP valid.
  - Immediate=1 for ADDI, SLTI, ANDI, ORI, LW, SW.
  - BEQ/BNE: AluOP=SUB, Branch=1, And=1, PcWrite=1 -> FETCH.
  - J: Jump=1, PcWrite=1 -> FETCH.
  - JAL: Jump=1, Jal=1, RegWrite=1, PcWrite=1 -> FETCH.
  - JR: JumpReg=1, PcWrite=1 -> FETCH.
  - OUT: Print=1, PcWrite=1 -> FETCH.
  - LW/SW -> MEM. All others -> WB.
- MEM:
  - AluOP=ADD, Immediate=1.
  - LW: MemRead=1 -> WB.
  - SW: MemWrite=1, PcWrite=1 -> FETCH.
- WB:
  - RegWrite=1, PcWrite=1. RegDst=1 for R-type only. MemToReg=1 for LW.
  - For IN: AluOP=PASS, InputAck=1.
  - -> FETCH.
- Latency: R/ALU-imm 4 cycles, LW 5, SW 4, branch/jump/OUT 3, IN 3 + wait.
- PcWrite is asserted in exactly the last cycle of every instruction. RetireCount increments in that same cycle and wraps 2^RETIRE_W-1 -> 0.
- WAIT_IN:
  - Leaves to WB only when InputValid=1 and Armed=1.
  - Armed clears on InputAck and sets on any cycle with InputValid=0.
  - A held button therefore cannot satisfy two consecutive IN instructions.
  - InputValid is ignored in every other state.
- HALT: Halted=1, all strobes 0, no exit except reset. RetireCount counts HLT when entering HALT.
- Reset mid-instruction: immediate return to FETCH with no partial strobes. In-flight MemWrite/RegWrite deassert asynchronously.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal opcode/funct in DECODE -> HALT and sets sticky output IllegalOp=1 (extra 1-bit port, reset 0). RetireCount does not increment.
- ILLEGAL_TRAP_EN undefined: illegal opcode is a 2-cycle NOP (PcWrite=1 in DECODE, RetireCount increments). No IllegalOp port.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum/localparams
  - opcode and funct constants
  - AluOP encodings
- One sub-module, mips_alu_decode: combinational (op, funct) -> AluOP plus an illegal flag. It is reused by the datapath tests.
- The FSM, Armed flag and counter live in the top.

Test Plan:
- R-type ADD: OpCode=0x00, Funct=0x20 -> states 0,1,2,4. WB has RegWrite=1, RegDst=1, AluOP=0, PcWrite=1. RetireCount 0->1.
- LW (0x23) -> 5 cycles. MEM has MemRead=1, Immediate=1. WB has MemToReg=1. SW (0x2B) -> 4 cycles, MemWrite=1 only in MEM, no RegWrite.
- BEQ (0x04) -> 3 cycles. EXEC has Branch=1, And=1, AluOP=1, PcWrite=1. JAL (0x03) -> Jump=Jal=RegWrite=1 in EXEC.
- Two back-to-back IN with InputValid held high -> first completes (InputAck one cycle). Second waits in WAIT_IN until InputValid goes 0 then 1.
- OpCode=0x3D -> Halted=1 permanently, strobes 0 for 100 cycles. Rst_n pulse low mid-EXEC of ADDI -> State=0 asynchronously, RegWrite never asserted.
- OpCode=0x1F: with ILLEGAL_TRAP_EN -> Halted=1, IllegalOp=1. Without it -> PcWrite in DECODE, back to FETCH, RetireCount+1.
